// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC datapath for the single-cycle MIPS core.
// Holds the current PC, forms PC+step / branch / jump targets, and counts non-halted cycles.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        invert_zero,
  input  logic [25:0] instr_index,
  input  logic [15:0] branch_imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] next_pc,
  output logic        branch_taken,
  output logic [31:0] cycle_count
);

  logic [31:0] branch_off;

  // Word offset: sign-extend then scale by 4, so the result is always word aligned.
  assign branch_off    = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign pc_plus4      = pc + PC_STEP;
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
  assign branch_taken  = branch & (zero ^ invert_zero);

  // Jump outranks any branch decision.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      cycle_count <= '0;
    end else if (!halt) begin
      pc          <= next_pc;
      cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver pushes model expectations, monitor pops and compares.
// Two instances run in lockstep: default reset PC and a 0xFFFF_FFFC reset PC for wrap coverage.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] pc, p4, bt, jt, np, cc;
    logic        tk;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0, jump = 1'b0, branch = 1'b0, zero = 1'b0, invert_zero = 1'b0;
  logic [25:0] instr_index = '0;
  logic [15:0] branch_imm = '0;

  logic [31:0] pc0, p40, bt0, jt0, np0, cc0;
  logic        tk0;
  logic [31:0] pc1, p41, bt1, jt1, np1, cc1;
  logic        tk1;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] rst_val [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_cc [2];

  always #5 clock = ~clock;

  pc_fetch_unit dut0 (
    .clock(clock), .reset(reset), .halt(halt), .jump(jump), .branch(branch), .zero(zero),
    .invert_zero(invert_zero), .instr_index(instr_index), .branch_imm(branch_imm),
    .pc(pc0), .pc_plus4(p40), .branch_target(bt0), .jump_target(jt0), .next_pc(np0),
    .branch_taken(tk0), .cycle_count(cc0)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clock(clock), .reset(reset), .halt(halt), .jump(jump), .branch(branch), .zero(zero),
    .invert_zero(invert_zero), .instr_index(instr_index), .branch_imm(branch_imm),
    .pc(pc1), .pc_plus4(p41), .branch_target(bt1), .jump_target(jt1), .next_pc(np1),
    .branch_taken(tk1), .cycle_count(cc1)
  );

  // Reference: plain arithmetic from the architectural rules.
  function automatic exp_t model(input logic [31:0] cur, input logic [31:0] cnt);
    exp_t e;
    int   off;
    off    = int'($signed(branch_imm)) * 4;
    e.pc   = cur;
    e.cc   = cnt;
    e.p4   = cur + 32'd4;
    e.bt   = e.p4 + 32'(off);
    e.jt   = (e.p4 & 32'hF000_0000) | (32'(instr_index) * 32'd4);
    e.tk   = branch && (invert_zero ? !zero : zero);
    e.np   = jump ? e.jt : (e.tk ? e.bt : e.p4);
    return e;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = rst_val[d];
      m_cc[d] = 32'd0;
    end
  endtask

  task automatic step(input logic rst, input logic h, input logic j, input logic b, input logic z,
                      input logic iv, input logic [25:0] idx, input logic [15:0] imm);
    exp_t e;
    @(negedge clock);
    reset = rst; halt = h; jump = j; branch = b; zero = z; invert_zero = iv;
    instr_index = idx; branch_imm = imm;
    if (rst) model_reset();
    for (int d = 0; d < 2; d++) begin
      e = model(m_pc[d], m_cc[d]);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      if (!rst && !h) begin
        m_pc[d] = e.np;
        m_cc[d] = m_cc[d] + 32'd1;
      end
    end
  endtask

  task automatic async_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    model_reset();
  endtask

  // Monitor: samples mid-low-phase, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("pc", 0, pc0, e.pc);            chk("pc_plus4", 0, p40, e.p4);
        chk("branch_target", 0, bt0, e.bt); chk("jump_target", 0, jt0, e.jt);
        chk("next_pc", 0, np0, e.np);       chk("branch_taken", 0, 32'(tk0), 32'(e.tk));
        chk("cycle_count", 0, cc0, e.cc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("pc", 1, pc1, e.pc);            chk("pc_plus4", 1, p41, e.p4);
        chk("branch_target", 1, bt1, e.bt); chk("jump_target", 1, jt1, e.jt);
        chk("next_pc", 1, np1, e.np);       chk("branch_taken", 1, 32'(tk1), 32'(e.tk));
        chk("cycle_count", 1, cc1, e.cc);
      end
    end
  end

  initial begin
    int waited;
    rst_val[0] = 32'h0040_0000;
    rst_val[1] = 32'hFFFF_FFFC;
    model_reset();

    // Reset state, then three plain sequential edges.
    step(1, 0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, 0, '0, '0);
    // pc = 0x00400010: jump wins, alone and with a taken branch.
    step(0, 0, 1, 0, 0, 0, 26'h0100005, '0);
    step(0, 0, 1, 1, 1, 0, 26'h0100005, 16'h0008);
    // Get to 0x00400020 and examine BEQ sense with halt held.
    step(0, 0, 1, 0, 0, 0, 26'h0100008, '0);
    step(0, 1, 0, 1, 1, 0, '0, 16'hFFFE);
    step(0, 1, 0, 1, 0, 0, '0, 16'hFFFE);
    step(0, 0, 0, 1, 1, 0, '0, 16'hFFFE);
    // Back to 0x00400000 for BNE sense.
    step(0, 0, 1, 0, 0, 0, 26'h0100000, '0);
    step(0, 1, 0, 1, 0, 1, '0, 16'h0003);
    step(0, 1, 0, 1, 1, 1, '0, 16'h0003);
    step(0, 1, 0, 0, 1, 1, '0, 16'h8000);
    step(0, 0, 0, 1, 0, 1, '0, 16'h0003);
    // Jump to 0x00400040, then reset between edges.
    step(0, 0, 1, 0, 0, 0, 26'h0100010, '0);
    step(0, 0, 0, 0, 0, 0, '0, '0);
    async_reset();
    step(1, 0, 1, 1, 1, 0, 26'h3FFFFFF, 16'h7FFF);
    step(0, 0, 0, 0, 0, 0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ((i % 97) == 50) async_reset();
      step(r[31:29] == 3'b000 && (i % 97) == 50 ? 1'b1 : ((i % 97) == 50),
           r[2:0] == 3'b000, r[3] & r[4], r[5], r[6], r[7],
           26'($urandom), 16'($urandom));
    end
    step(0, 0, 0, 0, 0, 0, '0, '0);

    waited = 0;
    while ((q0.size() > 0 || q1.size() > 0) && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    #5;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and next-PC datapath for the single-cycle MIPS core. Holds the current instruction address in a reset-able register and computes PC+4, the branch target, and the jump target. Selects the next PC from jump/branch control and the ALU zero flag. Also provides a free-running cycle counter that replaces the per-cycle bookkeeping previously done by the clock generator. Sits between the control unit, the ALU zero output, and instruction memory.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded by reset (MIPS text-segment base).
- PC_STEP, 32'd4, sequential increment added to PC.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- halt  input  1  when 1, PC and cycle counter hold their values.
- jump  input  1  control: take the jump target.
- branch  input  1  control: instruction is a conditional branch.
- zero  input  1  ALU zero flag.
- invert_zero  input  1  control: 1 selects BNE sense, 0 selects BEQ sense.
- instr_index  input  26  instruction[25:0], the jump field.
- branch_imm  input  16  instruction[15:0], the branch offset in words.
- pc  output  32  current PC; drives the instruction-memory address.
- pc_plus4  output  32  pc + PC_STEP.
- branch_target  output  32  pc_plus4 + (sign_extend(branch_imm) << 2).
- jump_target  output  32  {pc_plus4[31:28], instr_index, 2'b00}.
- next_pc  output  32  value to be loaded at the next rising edge.
- branch_taken  output  1  branch & (zero ^ invert_zero).
- cycle_count  output  32  number of non-halted rising edges since reset.

## Operation
- All adders are 32-bit modulo 2^32. The carry-out is discarded and there is no overflow flag.
- branch_imm is sign-extended to 32 bits and shifted left by 2, giving a word offset of -131072..+131068 bytes relative to pc_plus4.
- Next-PC priority:
  - jump = 1: next_pc = jump_target. Branch inputs are ignored.
  - else branch_taken = 1: next_pc = branch_target.
  - else: next_pc = pc_plus4.
- branch_taken = 0 whenever branch = 0, regardless of zero or invert_zero.
- halt = 1: pc and cycle_count are unchanged. next_pc and the other combinational outputs continue to reflect the inputs.
- The cycle counter increments by 1 per non-halted edge and wraps from 0xFFFF_FFFF to 0.
- pc, pc_plus4, jump_target and next_pc are word aligned whenever pc is word aligned. branch_target is also word aligned, because the shifted sign-extended offset is always a multiple of 4. No alignment checking is performed.

## Timing
- reset asserted: pc is forced to RESET_PC and cycle_count to 0 immediately, without waiting for a clock edge. The values are held while reset stays high.
- Reset applies even if asserted in the middle of a cycle; any pending next_pc is discarded.
- First rising edge after reset deassertion, with halt = 0: pc <= next_pc and cycle_count <= 1.
- pc_plus4, branch_target, jump_target, branch_taken and next_pc are purely combinational from pc and the inputs. They settle within the same cycle.
- Zero-cycle latency from control inputs to next_pc. One-cycle latency from next_pc to pc.
- Reset-state outputs with default parameters and all other inputs at 0:
  - pc = 0x0040_0000
  - pc_plus4 = 0x0040_0004
  - next_pc = 0x0040_0004
  - branch_target = 0x0040_0004
  - jump_target = 0x0000_0000
  - branch_taken = 0
  - cycle_count = 0

## Test plan
- Reset, then 3 edges with all controls at 0 -> pc sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; cycle_count = 3.
- pc = 0x00400010, jump = 1, instr_index = 0x0100005 -> jump_target = 0x00400014; after the edge, pc = 0x00400014. Repeat with branch = 1 and zero = 1 as well -> the jump still wins.
- pc = 0x00400020, branch = 1, zero = 1, invert_zero = 0, branch_imm = 0xFFFE -> branch_target = 0x0040001C and branch_taken = 1. With zero = 0 -> branch_taken = 0 and next_pc = 0x00400024.
- BNE sense: branch = 1, invert_zero = 1, zero = 0, branch_imm = 0x0003, pc = 0x00400000 -> next_pc = 0x00400010. With zero = 1 -> next_pc = 0x00400004.
- pc = 0xFFFF_FFFC (reached via RESET_PC override) -> pc_plus4 = 0x0000_0000, which wraps. Hold halt = 1 for 2 edges -> pc and cycle_count are unchanged.
- Assert reset asynchronously between edges while pc = 0x00400040 -> pc = 0x00400000 and cycle_count = 0 before the next edge.
